// File: rtl/game_control_pkg.sv
// -----------------------------------------------------------------------------
// game_control_pkg
// Shared definitions for the game-flow controller and its consumers (the
// renderer imports this too): game state encodings, BCD score geometry and a
// helper that advances a packed 4-digit BCD value by one.
// -----------------------------------------------------------------------------
package game_control_pkg;

   // Game state encodings as seen on o_state
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2,
      ST_OVER   = 2'd3
   } game_state_t;

   localparam int DIGIT_W    = 4;
   localparam int NUM_DIGITS = 4;
   localparam int SCORE_W    = DIGIT_W * NUM_DIGITS;

   localparam logic [SCORE_W-1:0] SCORE_MAX = 16'h9999;

   // Ripple a +1 through the packed BCD digits, least significant first.
   // A digit at 9 becomes 0 and passes the carry upward. The caller handles
   // saturation at SCORE_MAX.
   function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] value);
      logic [SCORE_W-1:0] result;
      logic               carry;
      result = value;
      carry  = 1'b1;
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (carry) begin
            if (value[d*DIGIT_W +: DIGIT_W] == DIGIT_W'(9)) begin
               result[d*DIGIT_W +: DIGIT_W] = '0;
            end else begin
               result[d*DIGIT_W +: DIGIT_W] = value[d*DIGIT_W +: DIGIT_W] + 1'b1;
               carry = 1'b0;
            end
         end
      end
      return result;
   endfunction

endpackage

// File: rtl/game_control_bcd_counter4.sv
// -----------------------------------------------------------------------------
// bcd_counter4
// Four-digit BCD score counter. Synchronous clear has priority over increment.
// The count sticks at 9999 instead of wrapping back to 0000.
//
// Ports:
//   clk    in   system clock
//   clear  in   synchronous clear to 0000
//   inc    in   advance the score by one (ignored at 9999)
//   count  out  packed BCD score, [15:12] most significant digit
// -----------------------------------------------------------------------------
module bcd_counter4
   import game_control_pkg::*;
(
   input  logic               clk,
   input  logic               clear,
   input  logic               inc,
   output logic [SCORE_W-1:0] count
);

   // Score register: clear wins, increment only below the saturation point
   always_ff @(posedge clk) begin
      if (clear) begin
         count <= '0;
      end else if (inc && (count != SCORE_MAX)) begin
         count <= bcd_inc(count);
      end
   end

endmodule

// File: rtl/game_control.sv
// -----------------------------------------------------------------------------
// game_control
// Central game-flow controller. Tracks IDLE/RUN/PAUSED/OVER, divides the system
// clock into a game tick that only runs in RUN, flags jump presses during play
// and keeps the BCD score (one point per tick).
//
// Parameters:
//   TICK_DIV        clk cycles per game tick (>= 2)
// Ports:
//   clk             system clock
//   rst             synchronous active-high reset
//   i_pause_state   pause level (1 = paused)
//   i_jump          debounced jump button level
//   i_collide       one-cycle collision pulse
//   o_state         game state (0 IDLE, 1 RUN, 2 PAUSED, 3 OVER)
//   o_tick          one-cycle game tick, only in RUN
//   o_jump_start    one-cycle pulse on a jump press during RUN
//   o_score         4-digit BCD score, [15:12] most significant
// -----------------------------------------------------------------------------
module game_control
   import game_control_pkg::*;
#(
   parameter int TICK_DIV = 1000000
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               i_pause_state,
   input  logic               i_jump,
   input  logic               i_collide,
   output logic [1:0]         o_state,
   output logic               o_tick,
   output logic               o_jump_start,
   output logic [SCORE_W-1:0] o_score
);

   localparam int               DIV_W    = $clog2(TICK_DIV);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

   game_state_t       state;
   logic [DIV_W-1:0]  div_cnt;
   logic              jump_q;
   logic              tick_q;
   logic              jump_start_q;

   logic              jump_rise;
   logic              last_count;
   logic              score_clear;
   logic              score_inc;

   assign jump_rise  = i_jump & ~jump_q;
   assign last_count = (div_cnt == DIV_LAST);

   // Score control. A tick only happens in RUN when neither a collision nor a
   // pause claims the cycle; starting a game (from IDLE or OVER) zeroes it.
   always_comb begin
      score_clear = 1'b0;
      score_inc   = 1'b0;
      if (rst) begin
         score_clear = 1'b1;
      end else begin
         case (state)
            ST_IDLE, ST_OVER: score_clear = jump_rise;
            ST_RUN:           score_inc   = ~i_collide & ~i_pause_state & last_count;
            default:          ;
         endcase
      end
   end

   // Game FSM with the tick divider, edge detector and pulse outputs.
   // jump_q resets high so a button held through reset is not a press.
   // On collision or pause the divider keeps its value, so a last count
   // lost to either event produces no tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= ST_IDLE;
         div_cnt      <= '0;
         jump_q       <= 1'b1;
         tick_q       <= 1'b0;
         jump_start_q <= 1'b0;
      end else begin
         jump_q       <= i_jump;
         tick_q       <= 1'b0;
         jump_start_q <= 1'b0;
         case (state)
            ST_IDLE, ST_OVER: begin
               div_cnt <= '0;
               if (jump_rise) begin
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (i_collide) begin
                  state <= ST_OVER;
               end else if (i_pause_state) begin
                  state <= ST_PAUSED;
               end else begin
                  if (last_count) begin
                     div_cnt <= '0;
                     tick_q  <= 1'b1;
                  end else begin
                     div_cnt <= div_cnt + 1'b1;
                  end
                  jump_start_q <= jump_rise;
               end
            end
            ST_PAUSED: begin
               if (!i_pause_state) begin
                  state <= ST_RUN;
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   bcd_counter4 u_score (
      .clk   (clk),
      .clear (score_clear),
      .inc   (score_inc),
      .count (o_score)
   );

   assign o_state      = state;
   assign o_tick       = tick_q;
   assign o_jump_start = jump_start_q;

endmodule
